// File: rtl/sync_spram_if.sv
// Access bus for sync_spram: request/write side driven by the master, ready/read response driven by the RAM.
interface sync_spram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic                  req;
  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic                  clr;
  logic                  perr_inj;
  logic                  ready;
  logic [DATA_W-1:0]     rdata;
  logic                  rvalid;
  logic                  perr;

  modport master (
    output req, we, be, addr, wdata, clr, perr_inj,
    input  ready, rdata, rvalid, perr
  );

  modport slave (
    input  req, we, be, addr, wdata, clr, perr_inj,
    output ready, rdata, rvalid, perr
  );
endinterface

// File: rtl/sync_spram.sv
// Synchronous single-port RAM with self-clearing init engine, byte enables and 1-cycle registered read.
// Optional per-lane even parity storage is enabled by defining SPRAM_PARITY_EN.
module sync_spram #(
  parameter int              DATA_W  = 8,
  parameter int              ADDR_W  = 4,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input logic        clk,
  input logic        rst,
  sync_spram_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;

  typedef enum logic {INIT, IDLE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              ready;
  logic              init_wr;
  logic              acc, acc_wr, acc_rd;
  logic              perr_calc;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] rdata_p0;
  logic              rvalid_p0;
  logic              perr_p0;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)                          cnt <= '0;
    else if (state == IDLE && bus.clr) cnt <= '0;
    else if (state == INIT)           cnt <= cnt + 1'b1;
  end

  // next-state logic; clr during INIT is deliberately ignored
  always_comb begin
    state_nxt = state;
    case (state)
      INIT: if (cnt == ADDR_W'(DEPTH-1)) state_nxt = IDLE;
      IDLE: if (bus.clr)                 state_nxt = INIT;
      default: state_nxt = INIT;
    endcase
  end

  // outputs of the FSM
  always_comb begin
    ready   = 1'b0;
    init_wr = 1'b0;
    case (state)
      INIT: init_wr = 1'b1;
      IDLE: ready   = 1'b1;
      default: ;
    endcase
  end

  // clr wins over a same-cycle req, and a reset cycle never commits an access
  assign acc    = ready & bus.req & ~bus.clr & ~rst;
  assign acc_wr = acc & bus.we;
  assign acc_rd = acc & ~bus.we;

  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem[cnt] <= CLR_VAL;
    end else if (acc_wr) begin
      for (int k = 0; k < NB; k++)
        if (bus.be[k]) mem[bus.addr][8*k +: 8] <= bus.wdata[8*k +: 8];
    end
  end

`ifdef SPRAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];

  function automatic logic [NB-1:0] lane_par(input logic [DATA_W-1:0] d);
    logic [NB-1:0] p;
    for (int k = 0; k < NB; k++) p[k] = ^d[8*k +: 8];
    return p;
  endfunction

  // perr_inj flips the stored parity of the written lanes only
  always_ff @(posedge clk) begin
    if (init_wr) begin
      par[cnt] <= lane_par(CLR_VAL);
    end else if (acc_wr) begin
      for (int k = 0; k < NB; k++)
        if (bus.be[k]) par[bus.addr][k] <= (^bus.wdata[8*k +: 8]) ^ bus.perr_inj;
    end
  end

  assign perr_calc = |(lane_par(mem[bus.addr]) ^ par[bus.addr]);
`else
  wire unused_perr_inj = bus.perr_inj;
  assign perr_calc = 1'b0;
`endif

  // read response stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_p0 <= 1'b0;
      perr_p0   <= 1'b0;
      rdata_p0  <= '0;
    end else begin
      rvalid_p0 <= acc_rd;
      perr_p0   <= acc_rd & perr_calc;
      if (acc_rd) rdata_p0 <= mem[bus.addr];
    end
  end

  assign bus.ready  = ready;
  assign bus.rdata  = rdata_p0;
  assign bus.rvalid = rvalid_p0;
  assign bus.perr   = perr_p0;
endmodule
